// File: rtl/buffer_access_sequencer_pkg.sv
// Shared types and helpers for the buffer access sequencer: FSM state encoding,
// request size encoding, default buffer depth and byte-lane select/insert.
package buffer_access_sequencer_pkg;

    localparam int BUF_DEPTH_DEFAULT = 64;

    typedef logic [1:0] req_size_t;

    // req_size carries the byte count minus one
    localparam req_size_t SIZE_1B = 2'd0;
    localparam req_size_t SIZE_2B = 2'd1;
    localparam req_size_t SIZE_3B = 2'd2;
    localparam req_size_t SIZE_4B = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_XFER  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] data);
        logic [31:0] w;
        w = word;
        w[8*lane +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/buffer_access_sequencer_if.sv
// AHB-side request/response and flush signalling between the slave register
// block (master modport) and the buffer access sequencer (slave modport).
interface buffer_access_sequencer_if;
    import buffer_access_sequencer_pkg::*;

    logic        req_valid;
    logic        req_write;
    req_size_t   req_size;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        hold;
    logic        flush_req;

    modport master (
        output req_valid, req_write, req_size, req_wdata, flush_req,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, hold
    );

    modport slave (
        input  req_valid, req_write, req_size, req_wdata, flush_req,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, hold
    );

endinterface

// File: rtl/buffer_access_sequencer.sv
// Splits one 1-4 byte AHB buffer access into byte-wide FIFO pops/pushes after an
// occupancy check, and keeps buffer flushes from interleaving with a partial word.
module buffer_access_sequencer
    import buffer_access_sequencer_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    parameter int OCC_W     = 7
) (
    input  logic                     clk,
    input  logic                     n_rst,
    buffer_access_sequencer_if.slave bus,
    input  logic [OCC_W-1:0]         buffer_occupancy,
    input  logic [7:0]               rx_data,
    output logic                     get_rx_data,
    output logic                     store_tx_data,
    output logic [7:0]               tx_data,
    output logic                     clear
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CHECK = ST_CHECK;
    localparam logic [2:0] S_XFER  = ST_XFER;
    localparam logic [2:0] S_RESP  = ST_RESP;
    localparam logic [2:0] S_FLUSH = ST_FLUSH;

    localparam logic [OCC_W:0] DEPTH_EXT = (OCC_W+1)'(BUF_DEPTH);

    logic [2:0]  state;
    logic        flush_pend;
    logic        wr_q;
    req_size_t   size_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  cnt;
    logic        err_q;

    logic           flush_now;
    logic [OCC_W:0] occ_ext;
    logic [OCC_W:0] need_ext;
    logic           rd_ok;
    logic           wr_ok;
    logic           chk_ok;

    // A flush request arriving this very cycle counts as pending
    assign flush_now = flush_pend | bus.flush_req;

    // Occupancy check done one bit wider so occupancy + bytes cannot wrap
    assign occ_ext  = {1'b0, buffer_occupancy};
    assign need_ext = (OCC_W+1)'(size_q) + (OCC_W+1)'(1);
    assign rd_ok    = (occ_ext >= need_ext);
    assign wr_ok    = ((occ_ext + need_ext) <= DEPTH_EXT);
    assign chk_ok   = wr_q ? wr_ok : rd_ok;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state      <= S_IDLE;
            flush_pend <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= SIZE_1B;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            cnt        <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            if (bus.flush_req) begin
                flush_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (flush_now) begin
                        state      <= S_FLUSH;
                        flush_pend <= 1'b0;
                    end else if (bus.req_valid) begin
                        state   <= S_CHECK;
                        wr_q    <= bus.req_write;
                        size_q  <= bus.req_size;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= 32'h0;
                        cnt     <= 2'd0;
                        err_q   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (chk_ok) begin
                        state <= S_XFER;
                    end else begin
                        state <= S_RESP;
                        err_q <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (!wr_q) begin
                        rdata_q <= lane_put(rdata_q, cnt, rx_data);
                    end
                    if (cnt == size_q) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RESP: begin
                    if (flush_now) begin
                        state      <= S_FLUSH;
                        flush_pend <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = (state == S_IDLE) && bus.req_valid && !flush_now && !n_rst;
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_err   = (state == S_RESP) && err_q;
        bus.rsp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
        bus.hold      = (state != S_IDLE);
        get_rx_data   = (state == S_XFER) && !wr_q;
        store_tx_data = (state == S_XFER) && wr_q;
        tx_data       = store_tx_data ? lane_get(wdata_q, cnt) : 8'h00;
        clear         = (state == S_FLUSH);
    end

endmodule

// File: tb/tb_buffer_access_sequencer.sv
// Bench for buffer_access_sequencer: a queue-backed byte buffer reacts to the DUT,
// and each request's timeline and result are predicted from the buffer contents.
module tb_buffer_access_sequencer;
    import buffer_access_sequencer_pkg::*;

    localparam int OCC_W = 7;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [OCC_W-1:0] buffer_occupancy;
    logic [7:0]       rx_data;
    logic             get_rx_data;
    logic             store_tx_data;
    logic [7:0]       tx_data;
    logic             clear;

    buffer_access_sequencer_if bus_if ();

    buffer_access_sequencer #(.BUF_DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .bus              (bus_if),
        .buffer_occupancy (buffer_occupancy),
        .rx_data          (rx_data),
        .get_rx_data      (get_rx_data),
        .store_tx_data    (store_tx_data),
        .tx_data          (tx_data),
        .clear            (clear)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic        s_get, s_store, s_clear;
    logic [7:0]  s_tx;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic sync_buf();
        buffer_occupancy = OCC_W'(mem.size());
        rx_data          = (mem.size() > 0) ? mem[0] : 8'h00;
    endtask

    task automatic sample();
        @(negedge clk);
        s_get   = get_rx_data;
        s_store = store_tx_data;
        s_clear = clear;
        s_tx    = tx_data;
    endtask

    // The buffer acts on the strobes the DUT showed during the cycle just ending
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_get && mem.size() > 0) void'(mem.pop_front());
        if (s_store) mem.push_back(s_tx);
        if (s_clear) mem.delete();
        s_get   = 1'b0;
        s_store = 1'b0;
        s_clear = 1'b0;
        sync_buf();
    endtask

    task automatic fill(input int n);
        mem.delete();
        for (int i = 0; i < n; i++) mem.push_back(8'($urandom));
        sync_buf();
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, ".req_ready"}, bus_if.req_ready, 1'b0);
        chk1({tag, ".rsp_valid"}, bus_if.rsp_valid, 1'b0);
        chk ({tag, ".rsp_rdata"}, bus_if.rsp_rdata, 32'h0);
        chk1({tag, ".rsp_err"}, bus_if.rsp_err, 1'b0);
        chk1({tag, ".hold"}, bus_if.hold, 1'b0);
        chk1({tag, ".get"}, get_rx_data, 1'b0);
        chk1({tag, ".store"}, store_tx_data, 1'b0);
        chk ({tag, ".tx_data"}, 32'(tx_data), 32'h0);
        chk1({tag, ".clear"}, clear, 1'b0);
    endtask

    // One request from acceptance to return to IDLE, with an optional flush_req
    // pulse flush_off cycles after acceptance.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] wd,
                          input int flush_off, input logic keep_valid);
        int          n, occ, rsp_off;
        logic        err, flush_after, xfer;
        logic [31:0] exp_rd;
        n   = int'(sz) + 1;
        occ = mem.size();
        err = wr ? (occ + n > DEPTH) : (occ < n);
        exp_rd = 32'h0;
        if (!wr && !err)
            for (int i = 0; i < n; i++) exp_rd |= 32'(mem[i]) << (8 * i);
        rsp_off     = err ? 2 : 2 + n;
        flush_after = (flush_off >= 1) && (flush_off <= rsp_off);

        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_size  = sz;
        bus_if.req_wdata = wd;
        bus_if.flush_req = 1'b0;
        sample();
        chk1("accept.req_ready", bus_if.req_ready, 1'b1);
        chk1("accept.hold", bus_if.hold, 1'b0);
        tick();

        for (int k = 1; k <= rsp_off; k++) begin
            xfer = !err && (k >= 2) && (k < 2 + n);
            bus_if.req_valid = keep_valid;
            bus_if.flush_req = (k == flush_off);
            sample();
            chk1("busy.hold", bus_if.hold, 1'b1);
            chk1("busy.req_ready", bus_if.req_ready, 1'b0);
            chk1("busy.get", get_rx_data, xfer && !wr);
            chk1("busy.store", store_tx_data, xfer && wr);
            chk1("busy.clear", clear, 1'b0);
            chk1("busy.rsp_valid", bus_if.rsp_valid, k == rsp_off);
            if (xfer && wr) chk("busy.tx_data", 32'(tx_data), (wd >> (8 * (k - 2))) & 32'hFF);
            if (k == rsp_off) begin
                chk ("rsp.rdata", bus_if.rsp_rdata, exp_rd);
                chk1("rsp.err", bus_if.rsp_err, err);
                last_rdata = bus_if.rsp_rdata;
                last_err   = bus_if.rsp_err;
            end
            tick();
        end
        bus_if.req_valid = 1'b0;
        bus_if.flush_req = 1'b0;

        if (flush_after) begin
            sample();
            chk1("flush.clear", clear, 1'b1);
            chk1("flush.hold", bus_if.hold, 1'b1);
            chk1("flush.rsp_valid", bus_if.rsp_valid, 1'b0);
            chk1("flush.get", get_rx_data, 1'b0);
            chk1("flush.store", store_tx_data, 1'b0);
            tick();
        end
        sample();
        chk1("idle.hold", bus_if.hold, 1'b0);
        chk1("idle.clear", clear, 1'b0);
        chk1("idle.rsp_valid", bus_if.rsp_valid, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_get = 1'b0; s_store = 1'b0; s_clear = 1'b0; s_tx = 8'h00;
        last_rdata = 32'h0; last_err = 1'b0;
        n_rst = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_size  = SIZE_1B;
        bus_if.req_wdata = 32'h0;
        bus_if.flush_req = 1'b0;
        fill(0);
        tick();
        tick();
        sample();
        chk_quiet("reset");
        tick();
        n_rst = 1'b0;

        // Four-byte read of 0x11..0x44 from a 10-byte buffer
        fill(6);
        mem.push_front(8'h44); mem.push_front(8'h33);
        mem.push_front(8'h22); mem.push_front(8'h11);
        sync_buf();
        do_req(1'b0, SIZE_4B, 32'h0, -1, 1'b0);
        chk ("tp_read.rdata", last_rdata, 32'h44332211);
        chk1("tp_read.err", last_err, 1'b0);

        // Two-byte write into a buffer with two free slots
        fill(62);
        do_req(1'b1, SIZE_2B, 32'hAABBCCDD, -1, 1'b0);
        chk1("tp_write.err", last_err, 1'b0);
        chk ("tp_write.occ", mem.size(), 64);
        chk ("tp_write.byte0", 32'(mem[62]), 32'hDD);
        chk ("tp_write.byte1", 32'(mem[63]), 32'hCC);

        // Overflowing write and underflowing read are refused
        fill(62);
        do_req(1'b1, SIZE_4B, 32'h01020304, -1, 1'b0);
        chk1("wr_over.err", last_err, 1'b1);
        chk ("wr_over.occ", mem.size(), 62);
        fill(1);
        do_req(1'b0, SIZE_2B, 32'h0, -1, 1'b0);
        chk1("rd_under.err", last_err, 1'b1);
        chk ("rd_under.occ", mem.size(), 1);

        // Exact-fit boundaries pass
        fill(60);
        do_req(1'b1, SIZE_4B, 32'h5A5A5A5A, -1, 1'b0);
        chk1("wr_exact.err", last_err, 1'b0);
        fill(4);
        do_req(1'b0, SIZE_4B, 32'h0, -1, 1'b0);
        chk1("rd_exact.err", last_err, 1'b0);
        chk ("rd_exact.occ", mem.size(), 0);

        // Flush and request together in IDLE: flush wins, request waits one cycle
        fill(8);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_size  = SIZE_1B;
        bus_if.flush_req = 1'b1;
        sample();
        chk1("same.req_ready", bus_if.req_ready, 1'b0);
        chk1("same.hold", bus_if.hold, 1'b0);
        tick();
        bus_if.flush_req = 1'b0;
        sample();
        chk1("same.clear", clear, 1'b1);
        chk1("same.req_ready_fl", bus_if.req_ready, 1'b0);
        tick();
        do_req(1'b0, SIZE_1B, 32'h0, -1, 1'b0);
        chk1("same.after_err", last_err, 1'b1);

        // Flush raised mid-transfer is deferred until after the response
        fill(10);
        do_req(1'b0, SIZE_4B, 32'h0, 3, 1'b1);
        chk ("defer.occ", mem.size(), 0);

        // Reset during XFER with a flush pending
        fill(10);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_size  = SIZE_4B;
        sample();
        chk1("mid_rst.accept", bus_if.req_ready, 1'b1);
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.flush_req = 1'b1;
        sample();
        tick();
        bus_if.flush_req = 1'b0;
        sample();
        chk1("mid_rst.get", get_rx_data, 1'b1);
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        sample();
        chk_quiet("mid_rst");
        tick();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk1("mid_rst.no_clear", clear, 1'b0);
            chk1("mid_rst.no_rsp", bus_if.rsp_valid, 1'b0);
            chk1("mid_rst.no_hold", bus_if.hold, 1'b0);
            tick();
        end

        // Randomized requests biased towards the occupancy limits
        for (int t = 0; t < 40; t++) begin
            logic       wr;
            logic [1:0] sz;
            int         occ, fo;
            wr  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            occ = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 64))
                : (wr ? int'($urandom_range(59, 64)) : int'($urandom_range(0, 4)));
            fill(occ);
            fo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
            do_req(wr, sz, $urandom, fo, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/buffer_access_sequencer.md
Name: buffer_access_sequencer

Overview:
Controller that sequences AHB-side multi-byte data-buffer accesses into byte-wide FIFO operations. It sits between the AHB-lite slave register block and the shared data buffer. It converts one 1–4 byte read or write request into a series of get_rx_data / store_tx_data pulses, checks occupancy before moving any byte, and arbitrates buffer flush requests against data transfers so a clear never interleaves with a partial word.

Parameters:
BUF_DEPTH, 64, data buffer capacity in bytes
OCC_W, 7, width of the occupancy count (must hold 0..BUF_DEPTH)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous reset, active-high (n_rst=1 resets on the rising clk edge)
req_valid  in  1  AHB-side data-buffer access request
req_write  in  1  1=write to buffer (TX), 0=read from buffer (RX)
req_size  in  2  byte count minus one (0→1 byte … 3→4 bytes)
req_wdata  in  32  write word; byte k is at [8k+7:8k]
req_ready  out  1  request accepted this cycle
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  32  read word, zero-extended above the transferred bytes
rsp_err  out  1  qualifies rsp_valid: occupancy check failed, no bytes moved
hold  out  1  stall to the AHB slave; high while the sequencer is busy
flush_req  in  1  single-cycle flush request from the flush control register
buffer_occupancy  in  OCC_W  current buffer byte count
rx_data  in  8  buffer head byte, valid combinationally in the same cycle as get_rx_data
get_rx_data  out  1  pop one byte
store_tx_data  out  1  push one byte
tx_data  out  8  byte to push
clear  out  1  flush the buffer

Behaviour:
- Reset: state=IDLE. All outputs are 0. The flush-pending flag, byte counter and captured registers are cleared. Reset mid-transfer abandons the transfer and produces no rsp_valid.
- States: IDLE, CHECK, XFER, RESP, FLUSH.
- flush_req sets flush_pend in any state. flush_pend clears on entry to FLUSH.
- IDLE:
  - If flush_pend (including a flush_req arriving this same cycle), go to FLUSH. req_ready stays 0, and any concurrent request waits. Flush has priority.
  - Otherwise, if req_valid: req_ready=1 for that cycle, latch write/size/wdata, set cnt=0, go to CHECK.
- CHECK (one cycle, uses the live buffer_occupancy):
  - A read requires occupancy ≥ size+1.
  - A write requires occupancy + size + 1 ≤ BUF_DEPTH, computed at OCC_W+1 bits so it cannot wrap.
  - Pass: go to XFER. Fail: set err, go to RESP.
- XFER (one byte per cycle):
  - Read: get_rx_data=1, and rx_data is captured into lane cnt.
  - Write: store_tx_data=1, tx_data = wdata lane cnt.
  - When cnt==size, go to RESP; otherwise cnt+1.
  - Bytes are always transferred lane 0 first.
- RESP:
  - rsp_valid=1 for one cycle.
  - rsp_rdata holds the captured lanes, with unused lanes 0. It is 0 for writes and on error.
  - rsp_err=err. Then go to IDLE.
- FLUSH: clear=1 for exactly one cycle, then go to IDLE.
- hold = (state != IDLE).
- Latency: request accepted at cycle T. Response at T+2+n for n bytes, or T+2 on error.
- A flush_req during CHECK, XFER or RESP is deferred. FLUSH follows the response directly, before the next request is accepted.
- get_rx_data, store_tx_data and clear are mutually exclusive and never asserted outside XFER/FLUSH.
- A request with req_valid held after acceptance is not re-accepted until IDLE is reached again.

Decomposition:
- The shared package holds:
  - the state enum (IDLE, CHECK, XFER, RESP, FLUSH);
  - the req_size encoding constants;
  - BUF_DEPTH's default;
  - the byte-lane helper function (lane select/insert).
- No sub-module. The occupancy checker stays inline as combinational logic within the single module.

Test Plan:
- Read with occupancy=10, size=3, buffer bytes 0x11,0x22,0x33,0x44 → four get_rx_data pulses at T+2..T+5; rsp_valid at T+6 with rsp_rdata=0x44332211, rsp_err=0.
- Write with occupancy=62, size=1, wdata=0xAABBCCDD → tx_data 0xDD then 0xCC, two store_tx_data pulses; rsp_valid with rsp_err=0.
- Write with occupancy=62, size=3 → rsp_err=1 at T+2, no store_tx_data. Read with occupancy=1, size=1 → rsp_err=1, no get_rx_data.
- flush_req and req_valid asserted in the same IDLE cycle → clear high for one cycle, req_ready 0; the request is accepted on the cycle after FLUSH.
- flush_req during XFER of a 4-byte read → all 4 pops complete, rsp_valid, then clear on the next cycle; hold stays high continuously through the response and flush.
- n_rst=1 in the middle of XFER → next cycle all outputs are 0, no rsp_valid, state IDLE; the previously pending flush is discarded.
